// File: rtl/control_unit.sv
// ---------------------------------------------------------------------------
// control_unit
//   Microprogrammed control sequencer for a two-byte-instruction accumulator
//   machine. Steps every instruction through fetch, decode, operand fetch and
//   execute, one micro-step per clock, and drives the registered 32-bit
//   micro-op word consumed by pc, mar, mbr, ir, br and acc.
//
// Ports
//   clk            in   1   system clock, rising edge
//   rst            in   1   asynchronous reset, active low
//   opcode         in   8   current IR contents (used only in decode)
//   acc_neg        in   1   ACC sign bit (used only when loading the JMPGEZ J word)
//   control_signal out 32   registered micro-op word for the current step
//   halted         out  1   high once HALT has executed, until reset
//   illegal_op     out  1   sticky flag, an undefined opcode was decoded
//   fetch_start    out  1   high during every F0 cycle
// ---------------------------------------------------------------------------
module control_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  opcode,
  input  logic        acc_neg,
  output logic [31:0] control_signal,
  output logic        halted,
  output logic        illegal_op,
  output logic        fetch_start
);

  localparam logic [7:0] OP_NOP    = 8'h00;
  localparam logic [7:0] OP_LOAD   = 8'h01;
  localparam logic [7:0] OP_STORE  = 8'h02;
  localparam logic [7:0] OP_ADD    = 8'h03;
  localparam logic [7:0] OP_SUB    = 8'h04;
  localparam logic [7:0] OP_JMP    = 8'h05;
  localparam logic [7:0] OP_JMPGEZ = 8'h06;
  localparam logic [7:0] OP_HALT   = 8'h07;

  // Micro-op bits of the control word.
  localparam logic [31:0] C_MAR_MBR = 32'h0000_0001; // bit 0
  localparam logic [31:0] C_MBR_PC  = 32'h0000_0002; // bit 1
  localparam logic [31:0] C_MAR_PC  = 32'h0000_0004; // bit 2
  localparam logic [31:0] C_PC_MBR  = 32'h0000_0008; // bit 3
  localparam logic [31:0] C_MEM_RD  = 32'h0000_0010; // bit 4
  localparam logic [31:0] C_MEM_WR  = 32'h0000_0020; // bit 5
  localparam logic [31:0] C_IR_MBR  = 32'h0000_0040; // bit 6
  localparam logic [31:0] C_MBR_ACC = 32'h0000_0080; // bit 7
  localparam logic [31:0] C_BR_MBR  = 32'h0000_0200; // bit 9
  localparam logic [31:0] C_ACC_ADD = 32'h0000_0400; // bit 10
  localparam logic [31:0] C_ACC_SUB = 32'h0000_0800; // bit 11
  localparam logic [31:0] C_ACC_MBR = 32'h0000_1000; // bit 12
  localparam logic [31:0] C_PC_INC  = 32'h0010_0000; // bit 20
  localparam logic [31:0] C_HALT    = 32'h8000_0000; // bit 31

  typedef enum logic [3:0] {
    S_IDLE, S_F0, S_F1, S_F2, S_D,
    S_A0, S_A1, S_A2, S_E0, S_E1, S_E2,
    S_J, S_H
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_op;          // opcode captured at the edge ending D
  logic [31:0] r_ctrl;
  logic        r_halted;
  logic        r_illegal;
  logic        r_fetch;
  logic [31:0] w_word;
  logic        w_has_operand;
  logic        w_bad_op;

  assign w_has_operand = (opcode >= OP_LOAD) && (opcode <= OP_JMPGEZ);
  assign w_bad_op      = (opcode > OP_HALT);

  // Next-state logic. NOP and undefined opcodes both go straight back to F0.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    w_next = r_state;
    unique case (r_state)
      S_IDLE: w_next = S_F0;
      S_F0:   w_next = S_F1;
      S_F1:   w_next = S_F2;
      S_F2:   w_next = S_D;
      S_D: begin
        if (opcode == OP_HALT)  w_next = S_H;
        else if (w_has_operand) w_next = S_A0;
        else                    w_next = S_F0;
      end
      S_A0:   w_next = S_A1;
      S_A1:   w_next = (r_op == OP_JMP || r_op == OP_JMPGEZ) ? S_J : S_A2;
      S_A2:   w_next = S_E0;
      S_E0:   w_next = S_E1;
      S_E1:   w_next = (r_op == OP_ADD || r_op == OP_SUB) ? S_E2 : S_F0;
      S_E2:   w_next = S_F0;
      S_J:    w_next = S_F0;
      S_H:    w_next = S_H;
      default: w_next = S_IDLE;
    endcase
  end

  // Word for the step being entered. It is registered together with the
  // state, so the datapath sees it for exactly the cycle of that step. The
  // opcode is already captured before any opcode-dependent step is entered;
  // acc_neg is looked at only while entering J, i.e. at the edge ending A1.
  always_comb begin
    w_word = '0;
    unique case (w_next)
      S_F0, S_A0: w_word = C_MAR_PC;
      S_F1, S_A1: w_word = C_MEM_RD | C_PC_INC;
      S_F2:       w_word = C_IR_MBR;
      S_A2:       w_word = C_MAR_MBR;
      S_E0:       w_word = (r_op == OP_STORE) ? C_MBR_ACC : C_MEM_RD;
      S_E1: begin
        if (r_op == OP_LOAD)       w_word = C_ACC_MBR;
        else if (r_op == OP_STORE) w_word = C_MEM_WR;
        else                       w_word = C_BR_MBR;
      end
      S_E2:       w_word = (r_op == OP_ADD) ? C_ACC_ADD : C_ACC_SUB;
      S_J:        w_word = (r_op == OP_JMP || !acc_neg) ? C_PC_MBR : '0;
      S_H:        w_word = C_HALT;
      default:    w_word = '0;
    endcase
  end

  // NOTE: state and output registers use non-blocking assignments so every
  // flop samples the pre-edge values; only control registers live here, so
  // all of them take the asynchronous reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_op      <= OP_NOP;
      r_ctrl    <= '0;
      r_halted  <= 1'b0;
      r_illegal <= 1'b0;
      r_fetch   <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_ctrl    <= w_word;
      r_halted  <= (w_next == S_H);
      r_fetch   <= (w_next == S_F0);
      if (r_state == S_D) begin
        r_op <= opcode;
        if (w_bad_op) r_illegal <= 1'b1;
      end
    end
  end

  assign control_signal = r_ctrl;
  assign halted         = r_halted;
  assign illegal_op     = r_illegal;
  assign fetch_start    = r_fetch;

endmodule

// File: tb/tb_control_unit.sv
// ---------------------------------------------------------------------------
// tb_control_unit
//   Self-checking bench for control_unit. A behavioural model keeps a queue of
//   the micro-op words each instruction must produce (built from per-opcode
//   word lists), and a compare process checks every output on every falling
//   edge. Directed sections pin the model with literal words, then a long
//   randomized run with random opcodes, acc_neg and resets follows.
// ---------------------------------------------------------------------------
module tb_control_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  opcode = 8'h00;
  logic        acc_neg = 1'b0;
  logic [31:0] control_signal;
  logic        halted;
  logic        illegal_op;
  logic        fetch_start;

  int checks = 0;
  int errors = 0;

  control_unit dut (
    .clk            (clk),
    .rst            (rst),
    .opcode         (opcode),
    .acc_neg        (acc_neg),
    .control_signal (control_signal),
    .halted         (halted),
    .illegal_op     (illegal_op),
    .fetch_start    (fetch_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------------
  // Behavioural model: a queue of upcoming words. Bit 32 tags an F0 word
  // (fetch_start), and -1 stands for the JMPGEZ J word, resolved from acc_neg
  // at the edge that loads it.
  // ------------------------------------------------------------------------
  localparam longint F0_TAG = 64'h1_0000_0000;
  localparam longint J_COND = -1;

  longint      q[$];
  bit          seen_fetch = 0;
  bit          m_halt = 0;
  bit          m_ill = 0;
  logic [31:0] e_word = '0;
  bit          e_fs = 0;

  task automatic push_fetch();
    q.push_back(F0_TAG | 64'h4);
    q.push_back(64'h0010_0010);
    q.push_back(64'h40);
    q.push_back(64'h0);
  endtask

  task automatic push_tail(input logic [7:0] op);
    if (op >= 8'h01 && op <= 8'h06) begin
      q.push_back(64'h4);
      q.push_back(64'h0010_0010);
    end
    case (op)
      8'h01: begin q.push_back(64'h1); q.push_back(64'h10); q.push_back(64'h1000); end
      8'h02: begin q.push_back(64'h1); q.push_back(64'h80); q.push_back(64'h20); end
      8'h03: begin q.push_back(64'h1); q.push_back(64'h10); q.push_back(64'h200); q.push_back(64'h400); end
      8'h04: begin q.push_back(64'h1); q.push_back(64'h10); q.push_back(64'h200); q.push_back(64'h800); end
      8'h05: q.push_back(64'h8);
      8'h06: q.push_back(J_COND);
      default: ;
    endcase
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
      seen_fetch = 0;
      m_halt = 0;
      m_ill = 0;
      e_word = '0;
      e_fs = 0;
    end else begin
      if (!m_halt && q.size() == 0) begin
        if (!seen_fetch) begin
          push_fetch();
          seen_fetch = 1;
        end else if (opcode == 8'h07) begin
          m_halt = 1;
        end else begin
          if (opcode > 8'h07) m_ill = 1;
          push_tail(opcode);
          push_fetch();
        end
      end
      if (m_halt) begin
        e_word = 32'h8000_0000;
        e_fs = 0;
      end else begin
        longint v;
        v = q.pop_front();
        if (v == J_COND) begin
          e_word = acc_neg ? 32'h0 : 32'h8;
          e_fs = 0;
        end else begin
          e_word = v[31:0];
          e_fs = v[32];
        end
      end
    end
  end

  // Compare process: every cycle, away from the rising edge.
  always @(negedge clk) begin
    check("model_ctrl", control_signal, e_word);
    check("model_fetch_start", {31'b0, fetch_start}, {31'b0, e_fs});
    check("model_halted", {31'b0, halted}, {31'b0, m_halt});
    check("model_illegal", {31'b0, illegal_op}, {31'b0, m_ill});
  end

  // ------------------------------------------------------------------------
  // Directed helpers
  // ------------------------------------------------------------------------
  task automatic steps(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic step_word(input string name, input logic [31:0] exp);
    @(negedge clk);
    check(name, control_signal, exp);
  endtask

  // Called just after a falling edge: reset is asserted between edges and
  // released on the next falling edge.
  task automatic do_reset();
    #3 rst = 1'b0;
    #1;
    check("rst_ctrl", control_signal, 32'h0);
    check("rst_halted", {31'b0, halted}, 32'h0);
    check("rst_illegal", {31'b0, illegal_op}, 32'h0);
    check("rst_fetch_start", {31'b0, fetch_start}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  function automatic logic [7:0] pick_opcode();
    int r;
    r = $urandom_range(0, 99);
    if (r < 85)      return 8'($urandom_range(0, 6));
    else if (r < 96) return 8'($urandom_range(8, 255));
    else             return 8'h07;
  endfunction

  initial begin
    int halt_cycles;
    // Reset state.
    steps(2);
    check("reset_ctrl", control_signal, 32'h0);
    check("reset_fetch_start", {31'b0, fetch_start}, 32'h0);

    // NOP stream after reset release.
    opcode = 8'h00;
    rst = 1'b1;
    step_word("nop_f0", 32'h4);
    check("nop_f0_fetch_start", {31'b0, fetch_start}, 32'h1);
    step_word("nop_f1", 32'h0010_0010);
    check("nop_f1_fetch_start", {31'b0, fetch_start}, 32'h0);
    step_word("nop_f2", 32'h40);
    step_word("nop_d", 32'h0);
    step_word("nop_next_f0", 32'h4);

    // LOAD.
    opcode = 8'h01;
    steps(3);
    step_word("load_a0", 32'h4);
    step_word("load_a1", 32'h0010_0010);
    step_word("load_a2", 32'h1);
    step_word("load_e0", 32'h10);
    step_word("load_e1", 32'h1000);
    step_word("load_next_f0", 32'h4);

    // ADD then SUB.
    opcode = 8'h03;
    steps(8);
    step_word("add_e2", 32'h400);
    step_word("add_next_f0", 32'h4);
    opcode = 8'h04;
    steps(8);
    step_word("sub_e2", 32'h800);
    step_word("sub_next_f0", 32'h4);

    // JMPGEZ taken and not taken.
    opcode = 8'h06;
    acc_neg = 1'b0;
    steps(5);
    step_word("jmpgez_taken_j", 32'h8);
    step_word("jmpgez_taken_f0", 32'h4);
    acc_neg = 1'b1;
    steps(5);
    step_word("jmpgez_not_taken_j", 32'h0);
    step_word("jmpgez_not_taken_f0", 32'h4);
    acc_neg = 1'b0;

    // Illegal opcode: NOP timing, sticky flag.
    opcode = 8'hA5;
    steps(3);
    step_word("illegal_f0", 32'h4);
    check("illegal_flag", {31'b0, illegal_op}, 32'h1);

    // Reset in ADD E1.
    opcode = 8'h03;
    steps(7);
    step_word("add_e1", 32'h200);
    do_reset();
    step_word("post_reset_f0", 32'h4);
    check("post_reset_fetch_start", {31'b0, fetch_start}, 32'h1);

    // HALT: held regardless of opcode.
    opcode = 8'h07;
    steps(3);
    for (int i = 0; i < 22; i++) begin
      step_word("halt_word", 32'h8000_0000);
      check("halt_flag", {31'b0, halted}, 32'h1);
      opcode = pick_opcode();
    end
    do_reset();

    // Randomized run.
    halt_cycles = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      opcode = pick_opcode();
      acc_neg = 1'($urandom_range(0, 1));
      if (m_halt) halt_cycles++;
      if (halt_cycles > 25 || $urandom_range(0, 299) == 0) begin
        halt_cycles = 0;
        do_reset();
      end
    end

    steps(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
Microprogrammed control sequencer that drives the 32-bit control_signal bus consumed by pc, mar, mbr, ir, br and acc.
Steps each instruction through fetch, decode, operand fetch and execute, one micro-step per clock.
Opcode comes from the IR; branch condition comes from the ACC sign flag.
Machine: 8-bit address space, two-byte instructions (opcode byte, address byte).

Parameters:
OP_NOP, 8'h00, no-operation opcode
OP_LOAD, 8'h01, ACC <- mem[addr]
OP_STORE, 8'h02, mem[addr] <- ACC
OP_ADD, 8'h03, ACC <- ACC + mem[addr]
OP_SUB, 8'h04, ACC <- ACC - mem[addr]
OP_JMP, 8'h05, PC <- addr
OP_JMPGEZ, 8'h06, PC <- addr if ACC >= 0
OP_HALT, 8'h07, stop sequencing

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
opcode  input  8  current IR contents
acc_neg  input  1  ACC sign bit (1 = negative)
control_signal  output  32  registered micro-op word
halted  output  1  high once HALT has executed
illegal_op  output  1  sticky, high after any undefined opcode is decoded
fetch_start  output  1  high during every F0 cycle

Behaviour:
- Control bit map (all unlisted bits are always 0):
  - 0 MAR<-MBR; 1 MBR<-PC; 2 MAR<-PC; 3 PC<-MBR
  - 4 mem read (MBR<-mem[MAR]); 5 mem write (mem[MAR]<-MBR)
  - 6 IR<-MBR; 7 MBR<-ACC; 9 BR<-MBR; 10 ACC<-ACC+BR; 11 ACC<-ACC-BR; 12 ACC<-MBR
  - 20 PC<-PC+1; 31 halt marker
- Timing model:
  - control_signal and all outputs are registered Moore outputs.
  - The word for step S is present for exactly one cycle; the datapath consumes it at the rising edge that ends that cycle.
- Reset (rst=0, async):
  - state=IDLE, control_signal=0, halted=0, illegal_op=0, fetch_start=0.
  - The first edge after release moves to F0.
- Fetch (every instruction):
  - F0=bit2 (fetch_start=1)
  - F1=bit4|bit20
  - F2=bit6
  - D=0 (decode bubble; opcode sampled at the edge ending D)
- Operand fetch (opcodes 01..06):
  - A0=bit2
  - A1=bit4|bit20
- Execute sequences, each returning to F0:
  - NOP: D -> F0. Total 4 cycles.
  - LOAD: A0, A1, A2=bit0, E0=bit4, E1=bit12. Total 9 cycles.
  - STORE: A0, A1, A2=bit0, E0=bit7, E1=bit5. Total 9 cycles.
  - ADD: A0, A1, A2=bit0, E0=bit4, E1=bit9, E2=bit10. Total 10 cycles.
  - SUB: same as ADD, but E2=bit11. Total 10 cycles.
  - JMP: A0, A1, J=bit3. Total 7 cycles.
  - JMPGEZ: A0, A1, J.
    - J=bit3 if acc_neg==0, else J=0.
    - acc_neg is sampled at the edge that loads the J word.
    - Always 7 cycles, taken or not.
  - HALT: D -> H.
    - In H: control_signal=32'h8000_0000 held every cycle, halted=1.
    - Stays in H until reset.
- Illegal opcode (08..FF):
  - Sequenced as NOP (D -> F0).
  - illegal_op set at the edge ending D and held until reset.
- Opcode is ignored in every state except D.
- acc_neg is ignored in every state except A1->J of JMPGEZ.
- Reset mid-sequence: immediate return to IDLE with all outputs 0; no partial micro-op is completed afterwards.
- Never assert more than one of {bit1, bit3, bit7, mem read} in a word; never assert read and write together.

Test Plan:
- Reset release, opcode=00 -> cycle sequence 0, 0x4, 0x100010, 0x40, 0x0, then 0x4 again; fetch_start high only in F0 cycles.
- opcode=01 held at D -> words 0x4, 0x100010, 0x1, 0x10, 0x1000 after D, then F0; 9 cycles per instruction.
- opcode=03, then opcode=04 -> E2 word 0x400 for ADD, 0x800 for SUB; no bit 10/11 in any other cycle.
- opcode=06 with acc_neg=0 -> J word 0x8; repeat with acc_neg=1 -> J word 0x0; both return to F0 after 7 cycles.
- opcode=07 -> halted=1 from the cycle after D; control_signal=32'h8000_0000 for 20+ cycles; opcode changes have no effect.
- opcode=8'hA5 -> illegal_op=1 after D, NOP timing. Then assert rst during ADD E1 -> all outputs 0 immediately, illegal_op cleared, F0 on the first edge after release.
